// File: rtl/result_unpack_fifo_pkg.sv
// Shared types and constants for the result unpack FIFO: word/pair widths,
// half-select encoding and the storage entry layout.
package result_unpack_fifo_pkg;

  localparam int WORD_W       = 32;
  localparam int PAIR_W       = 64;
  localparam int RESULT_DEPTH = 512;

  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_e;

  // One stored entry: the packed pair plus its odd-tail marker.
  typedef struct packed {
    logic              single;
    logic [PAIR_W-1:0] pair;
  } entry_t;

endpackage

// File: rtl/result_unpack_fifo_if.sv
// Handshake bundle between the array drain (producer), the FIFO and the
// host readback (consumer), plus the FIFO status outputs.
interface result_unpack_fifo_if #(
  parameter int AW = 9
);
  import result_unpack_fifo_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PAIR_W-1:0] in_data;
  logic              in_single;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [AW:0]       level;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output in_valid, in_data, in_single, out_ready,
    input  in_ready, out_valid, out_data, level, empty, full, overflow
  );

  modport slave (
    input  in_valid, in_data, in_single, out_ready,
    output in_ready, out_valid, out_data, level, empty, full, overflow
  );

endinterface

// File: rtl/result_unpack_fifo_sync_fifo_mem.sv
// Entry storage for the result FIFO: one synchronous write port and one
// asynchronous (LUT-RAM style) read port; contents are never cleared.
module sync_fifo_mem
  import result_unpack_fifo_pkg::*;
#(
  parameter int DEPTH = RESULT_DEPTH,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  entry_t        wr_entry_i,
  input  logic [AW-1:0] rd_addr_i,
  output entry_t        rd_entry_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_entry_i;
    end
  end

  assign rd_entry_o = mem_q[rd_addr_i];

endmodule

// File: rtl/result_unpack_fifo.sv
// Result unpack FIFO: stores 64-bit result pairs and emits them as 32-bit
// words, upper (earlier) half first, through a registered output stage.
module result_unpack_fifo
  import result_unpack_fifo_pkg::*;
#(
  parameter int DEPTH = RESULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  result_unpack_fifo_if.slave bus
);

  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  half_e             rd_half_q, rd_half_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop, load;
  entry_t            wr_entry, rd_entry;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = bus.in_valid && !full;
  assign load  = !out_valid_q || bus.out_ready;

  assign wr_entry.pair   = bus.in_data;
  assign wr_entry.single = bus.in_single;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .wr_en_i    (push),
    .wr_addr_i  (wr_ptr_q),
    .wr_entry_i (wr_entry),
    .rd_addr_i  (rd_ptr_q),
    .rd_entry_o (rd_entry)
  );

  // An entry is popped only once its last meaningful half has been loaded.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_half_d   = rd_half_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    if (load) begin
      if (!empty) begin
        out_valid_d = 1'b1;
        out_data_d  = (rd_half_q == HALF_LOWER) ? rd_entry.pair[WORD_W-1:0]
                                                : rd_entry.pair[PAIR_W-1:WORD_W];
        if (rd_half_q == HALF_UPPER && !rd_entry.single) begin
          rd_half_d = HALF_LOWER;
        end else begin
          pop       = 1'b1;
          rd_half_d = HALF_UPPER;
          rd_ptr_d  = rd_ptr_q + AW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    overflow_d = overflow_q || (bus.in_valid && full);
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_half_q   <= HALF_UPPER;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_half_q   <= rd_half_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.level     = level_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_result_unpack_fifo.sv
// Bench for result_unpack_fifo: a word-queue model fed by accepted pushes and
// checked on every output handshake, plus directed literal expectations.
module tb_result_unpack_fifo;
  import result_unpack_fifo_pkg::*;

  localparam int DEPTH = RESULT_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_unpack_fifo_if #(.AW(AW)) bus ();

  result_unpack_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_words = 0;
  logic [31:0] exp_q[$];
  bit          mdl_ovf = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] stall_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: every accepted pair appends its meaningful words in emit order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_ovf = 1'b0;
      stalled = 1'b0;
    end else begin
      check("overflow", bus.overflow, mdl_ovf);
      check("level_bound", bus.level <= DEPTH, 1);
      check("flags", {bus.full, bus.empty, bus.in_ready},
            {bus.level == DEPTH, bus.level == 0, bus.level != DEPTH});
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_word: got %0h expected no word", bus.out_data);
        end else begin
          check("word_order", bus.out_data, exp_q.pop_front());
        end
      end
      stalled    = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (bus.in_valid && !bus.in_ready) mdl_ovf = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data[63:32]);
        if (!bus.in_single) exp_q.push_back(bus.in_data[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [63:0] d, input logic s);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_single = s;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_single = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    bus.out_ready = 1'b1;
    while (!(bus.empty && !bus.out_valid) && cyc < 4 * DEPTH) begin
      tick();
      cyc++;
    end
    check({name, "_timeout"}, cyc < 4 * DEPTH, 1);
    check({name, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    int acc;
    int cyc;
    logic [3:0] rdy_pat;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_single = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_level", bus.level, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_overflow", bus.overflow, 0);

    // 1: basic pair, latency and order
    push1(64'h11111111_22222222, 1'b0);
    check("t1_lat_k", bus.out_valid, 0);
    check("t1_level", bus.level, 1);
    tick();
    check("t1_valid0", bus.out_valid, 1);
    check("t1_word0", bus.out_data, 32'h11111111);
    tick();
    check("t1_valid1", bus.out_valid, 1);
    check("t1_word1", bus.out_data, 32'h22222222);
    tick();
    check("t1_done", bus.out_valid, 0);
    check("t1_empty", bus.empty, 1);

    // 2: odd tail emits only the upper word
    push1(64'h0000000A_0000000B, 1'b1);
    tick();
    check("t2_valid", bus.out_valid, 1);
    check("t2_word", bus.out_data, 32'h0000000A);
    tick();
    check("t2_done", bus.out_valid, 0);
    check("t2_level", bus.level, 0);

    // 3: fill to DEPTH, overflow, drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w0 = 32'h3000_0000 + 2 * i;
      push1({w0[31:0], w0[31:0] + 32'd1}, 1'b0);
    end
    check("t3_full", bus.full, 1);
    check("t3_in_ready", bus.in_ready, 0);
    check("t3_level", bus.level, DEPTH);
    push1(64'hDEADBEEF_DEADBEEF, 1'b0);
    check("t3_overflow", bus.overflow, 1);
    check("t3_level_kept", bus.level, DEPTH);
    n_words = 0;
    drain("t3_drain");
    check("t3_word_count", n_words, 2 * DEPTH);

    // 4: backpressure pattern 1,0,0,1 mid-stream
    rdy_pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = rdy_pat[i % 4];
      bus.in_valid  = (i < 6);
      bus.in_data   = {32'hE000_0000 + 32'(2 * i), 32'hE000_0001 + 32'(2 * i)};
      tick();
    end
    bus.in_valid = 1'b0;
    drain("t4_drain");

    // 5: random traffic across several pointer wraps
    acc = 0;
    cyc = 0;
    while (acc < 3 * DEPTH && cyc < 40000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_single = ($urandom_range(0, 7) == 0);
      bus.in_data   = {32'h5000_0000 + 32'(2 * acc), 32'h5000_0001 + 32'(2 * acc)};
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.in_single = 1'b0;
    check("t5_all_pushed", acc, 3 * DEPTH);
    drain("t5_drain");

    // 6: reset mid-stream with data held in the output register
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push1({32'h7000_0000 + 32'(i), 32'h7100_0000 + 32'(i)}, 1'b0);
    tick();
    check("t6_pre_valid", bus.out_valid, 1);
    check("t6_pre_level", bus.level, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", bus.out_valid, 0);
    check("t6_level", bus.level, 0);
    check("t6_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    push1(64'h0000000C_0000000D, 1'b0);
    tick();
    check("t6_word0", bus.out_data, 32'h0000000C);
    tick();
    check("t6_word1", bus.out_data, 32'h0000000D);
    tick();
    check("t6_done", bus.out_valid, 0);
    check("t6_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_unpack_fifo.md
Name: result_unpack_fifo

Overview:
- Output-side counterpart of the array input buffer.
- Accepts 64-bit packed result pairs from the systolic array drain, stores them, and emits them as single 32-bit words to the host/readback path.
- Upper half [63:32] is the earlier element and is emitted first; lower half [31:0] follows. This is the same pairing order the input buffer uses when it packs two words.
- Valid/ready on both sides; full/empty tracking; sticky overflow flag.

Parameters:
- DEPTH, 512, number of 64-bit entries (power of 2).
- AW, 9, entry pointer width = log2(DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  packed pair offered.
- in_ready  out  1  = !full (combinational from registered count).
- in_data  in  64  {earlier word, later word}.
- in_single  in  1  with in_valid: only [63:32] is meaningful (odd tail); [31:0] is ignored.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts.
- out_data  out  32  unpacked word.
- level  out  AW+1  entries currently stored (0..DEPTH).
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky: set when in_valid && full; cleared only by rst.

Behaviour:
- Storage:
  - Arrays mem[DEPTH] x 64 and single_flag[DEPTH] x 1.
  - Write pointer wr_ptr and read pointer rd_ptr, each AW bits, wrapping modulo DEPTH naturally.
  - rd_half selects the half to emit: 0 = upper, 1 = lower.
  - Memory read is asynchronous (LUT-RAM style).
- Push: in_valid && in_ready at edge → mem[wr_ptr] <= in_data, single_flag[wr_ptr] <= in_single, wr_ptr+1. A push while full is dropped and sets overflow.
- Output register load condition: load = !out_valid || out_ready.
  - If load && !empty: out_data <= rd_half ? mem[rd_ptr][31:0] : mem[rd_ptr][63:32]; out_valid <= 1.
  - If load && empty: out_valid <= 0; out_data holds its last value.
- Half / pop sequencing on each load from a non-empty FIFO:
  - rd_half==0 && single_flag[rd_ptr]: pop the entry (rd_ptr+1), rd_half stays 0.
  - rd_half==0 && !single: rd_half <= 1, no pop.
  - rd_half==1: pop, rd_half <= 0.
- Level update:
  - Push and pop in the same cycle: level unchanged.
  - Push only: +1. Pop only: -1.
  - in_ready is evaluated from the pre-edge level, so no push is accepted at DEPTH even if a pop happens in the same cycle.
- Latency:
  - Handshake accepted at edge k with the FIFO and output empty → out_valid=1 after edge k+1.
  - Sustained throughput: one 32-bit word per cycle out; one entry per 2 cycles in at steady state.
- Wrap: pointers roll DEPTH-1 → 0 with no gap; level stays exact across the wrap.
- out_data must remain stable while out_valid && !out_ready.
- Reset (any cycle, including mid-stream):
  - wr_ptr, rd_ptr, rd_half, level <= 0.
  - out_valid, overflow <= 0; out_data <= 0.
  - Stored contents are discarded (memory itself is not cleared).
  - in_ready is 1 in the first cycle after reset.

Decomposition:
- Shared package (array_pkg):
  - WORD_W=32, PAIR_W=64.
  - Half-select constants HALF_UPPER=0, HALF_LOWER=1.
  - Default result-buffer depth.
- One natural sub-module: sync_fifo_mem. It owns the 65-bit-wide memory (data + single flag) with write port and async read. The top level holds the pointers, level, half sequencer and output register.

Test Plan:
1. Reset, then push 0x11111111_22222222 with out_ready=1 → out_valid rises after edge k+1; out_data 0x11111111 then 0x22222222 on consecutive cycles; empty=1 afterwards.
2. Push pair 0xA_B with in_single=1 (upper=0x0000000A) → exactly one word 0x0000000A emitted, then out_valid=0; level returns to 0.
3. Hold out_ready=0 and push DEPTH entries → full=1, in_ready=0, level=DEPTH. One extra in_valid → overflow=1 and the entry is not stored. Drain → 2*DEPTH words in order, no loss or duplication.
4. Backpressure: toggle out_ready 1,0,0,1 mid-stream → out_data constant while stalled; word order is preserved.
5. Wrap: push/pop 3*DEPTH pairs with random valid/ready → output sequence equals input words in upper-then-lower order; level never exceeds DEPTH.
6. Assert rst while 5 entries are stored and out_valid=1 → next cycle out_valid=0, level=0, in_ready=1. A new push 0xC_D is emitted as 0xC, 0xD with no stale data.
